// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline datapath and its hazard controller.
// The pipeline (master) presents register indices, write enables and memory status.
// The controller (slave) returns stall/flush enables, forwarding selects and status.
// None of these signals handshake: every output is a same-cycle function of the inputs
// and the controller state. There is no valid/ready pair in this bundle.
interface pipeline_hazard_ctrl_if #(
    parameter int STALL_CNT_W = 32
);
    logic [4:0]             Rs1D;
    logic [4:0]             Rs2D;
    logic [4:0]             Rs1E;
    logic [4:0]             Rs2E;
    logic [4:0]             RdE;
    logic [4:0]             RdM;
    logic [4:0]             RdW;
    logic                   RegWriteM;
    logic                   RegWriteW;
    logic [1:0]             ResultSrcE;
    logic                   PCSrcE;
    logic                   MemReqM;
    logic                   MemReadyM;

    logic [1:0]             ForwardAE;
    logic [1:0]             ForwardBE;
    logic                   StallF;
    logic                   StallD;
    logic                   StallE;
    logic                   StallM;
    logic                   FlushD;
    logic                   FlushE;
    logic                   FlushW;
    logic                   MemErr;
    logic [STALL_CNT_W-1:0] StallCount;
    logic [1:0]             state_dbg;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW, MemErr, StallCount, state_dbg
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW, MemErr, StallCount, state_dbg
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RISC-V pipeline.
// It produces the stall/flush enables and the E-stage forwarding selects.
// It runs a post-reset flush sequence and a data-memory wait handshake with a timeout.
// It keeps a saturating count of stall cycles.
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 15,
    parameter int STALL_CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);

    localparam int WC_W = ($clog2(MEM_TIMEOUT + 1) > 4) ? $clog2(MEM_TIMEOUT + 1) : 4;
    localparam int IC_W = ($clog2(FLUSH_CYCLES + 1) > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    // With no flush cycles requested the controller comes out of reset already running.
    localparam state_t            RESET_STATE = (FLUSH_CYCLES == 0) ? ST_RUN : ST_INIT;
    localparam logic [WC_W-1:0]   TIMEOUT_V   = WC_W'(MEM_TIMEOUT);
    localparam logic [IC_W-1:0]   INIT_V      = IC_W'(FLUSH_CYCLES);

    state_t                 state_q, state_d;
    logic [IC_W-1:0]        init_cnt_q, init_cnt_d;
    logic [WC_W-1:0]        wait_cnt_q, wait_cnt_d;
    logic                   mem_err_q, mem_err_d;
    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

    logic       mem_stall;
    logic       lw_stall;
    logic [1:0] fwd_a, fwd_b;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_w;

    // Hazard detection: forwarding selects, load-use and memory-wait stalls, stall/flush enables.
    always_comb begin
        mem_stall = hz.MemReqM & ~hz.MemReadyM & (wait_cnt_q < TIMEOUT_V);
        lw_stall  = (hz.ResultSrcE == 2'b01) & (hz.RdE != 5'd0) &
                    ((hz.RdE == hz.Rs1D) | (hz.RdE == hz.Rs2D)) & ~hz.PCSrcE;
        fwd_a   = 2'b00;
        fwd_b   = 2'b00;
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (state_q == ST_INIT) begin
            stall_f = 1'b1;
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b1;
        end else begin
            // The M stage holds the younger result, so it wins over W.
            if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs1E)      fwd_a = 2'b10;
            else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs1E) fwd_a = 2'b01;
            if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs2E)      fwd_b = 2'b10;
            else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs2E) fwd_b = 2'b01;
            if (mem_stall) begin
                // Freeze everything up to M. A bubble goes into W so it does not retire twice.
                // Branch and load-use are re-evaluated after release, because E is held.
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else begin
                stall_f = lw_stall;
                stall_d = lw_stall;
                flush_d = hz.PCSrcE;
                flush_e = lw_stall | hz.PCSrcE;
            end
        end
    end

    // Next-state logic: flush sequencing, memory wait tracking, timeout error and stall counting.
    always_comb begin
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        mem_err_d     = mem_err_q;
        stall_count_d = stall_count_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q - IC_W'(1);
                if (init_cnt_q <= IC_W'(1)) begin
                    state_d    = ST_RUN;
                    init_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (mem_stall) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WC_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (mem_stall) begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                    // The access is still pending but out of budget, so this is a forced release.
                    if (hz.MemReqM && !hz.MemReadyM) mem_err_d = 1'b1;
                end
            end
            default: state_d = RESET_STATE;
        endcase
        if (state_q != ST_INIT && stall_f && stall_count_q != '1)
            stall_count_d = stall_count_q + STALL_CNT_W'(1);
    end

    // State registers, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RESET_STATE;
            init_cnt_q    <= INIT_V;
            wait_cnt_q    <= '0;
            mem_err_q     <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_err_q     <= mem_err_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign hz.ForwardAE  = fwd_a;
    assign hz.ForwardBE  = fwd_b;
    assign hz.StallF     = stall_f;
    assign hz.StallD     = stall_d;
    assign hz.StallE     = stall_e;
    assign hz.StallM     = stall_m;
    assign hz.FlushD     = flush_d;
    assign hz.FlushE     = flush_e;
    assign hz.FlushW     = flush_w;
    assign hz.MemErr     = mem_err_q;
    assign hz.StallCount = stall_count_q;
    assign hz.state_dbg  = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed vectors, literal checks and a per-cycle model.
module tb_pipeline_hazard_ctrl;

    localparam int FC = 2;
    localparam int MT = 15;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic check_en = 1'b0;

    pipeline_hazard_ctrl_if #(.STALL_CNT_W(CW)) hz ();

    pipeline_hazard_ctrl #(
        .FLUSH_CYCLES(FC),
        .MEM_TIMEOUT (MT),
        .STALL_CNT_W (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz)
    );

    // Clock generation
    always #5 clk = ~clk;

    // Model state:
    //   m_flush_left: flush cycles still owed after reset.
    //   m_waited: stall cycles already spent on the current memory access.
    int              m_flush_left = FC;
    int              m_waited     = 0;
    logic            m_err        = 1'b0;
    logic [CW-1:0]   m_cnt        = '0;

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (hz.RegWriteM && hz.RdM != 0 && hz.RdM == rs) return 2'b10;
        if (hz.RegWriteW && hz.RdW != 0 && hz.RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_mem_stall();
        return hz.MemReqM && !hz.MemReadyM && (m_waited < MT);
    endfunction

    function automatic logic m_load_use();
        return hz.ResultSrcE == 2'b01 && hz.RdE != 0 &&
               (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D) && !hz.PCSrcE;
    endfunction

    // Expected output word: {FwdA, FwdB, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr}
    function automatic logic [12:0] model_outputs();
        logic lu, ms;
        if (m_flush_left > 0) return {4'b0000, 4'b1000, 3'b111, m_err};
        lu = m_load_use();
        ms = m_mem_stall();
        if (ms) return {exp_fwd(hz.Rs1E), exp_fwd(hz.Rs2E), 4'b1111, 3'b001, m_err};
        return {exp_fwd(hz.Rs1E), exp_fwd(hz.Rs2E), lu, lu, 2'b00,
                hz.PCSrcE, lu | hz.PCSrcE, 1'b0, m_err};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: reset is asynchronous, and the rest advances on the clock.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_flush_left = FC;
            m_waited     = 0;
            m_err        = 1'b0;
            m_cnt        = '0;
        end else if (m_flush_left > 0) begin
            m_flush_left--;
        end else begin
            if ((m_mem_stall() || m_load_use()) && m_cnt != {CW{1'b1}}) m_cnt++;
            if (m_mem_stall()) begin
                m_waited++;
            end else begin
                if (hz.MemReqM && !hz.MemReadyM) m_err = 1'b1;
                m_waited = 0;
            end
        end
    end

    // Per-cycle compare of all DUT outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("cycle_outputs",
                {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.StallE, hz.StallM,
                 hz.FlushD, hz.FlushE, hz.FlushW, hz.MemErr},
                model_outputs());
            chk("cycle_count", hz.StallCount, m_cnt);
        end
    end

    task automatic idle();
        hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0;
        hz.RdE = 0; hz.RdM = 0; hz.RdW = 0;
        hz.RegWriteM = 0; hz.RegWriteW = 0; hz.ResultSrcE = 2'b00;
        hz.PCSrcE = 0; hz.MemReqM = 0; hz.MemReadyM = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        hz.ResultSrcE = 2'b01; hz.RdE = rd; hz.Rs2D = 5'd5;
    endtask

    // Directed stimulus with hand-computed expectations
    initial begin
        idle();
        #1 check_en = 1'b1;

        // Reset held
        @(negedge clk);
        chk("reset_stallf", hz.StallF, 1);
        chk("reset_flushw", hz.FlushW, 1);
        chk("reset_stallm", hz.StallM, 0);
        chk("reset_count",  hz.StallCount, 0);

        // Release reset: exactly two flush cycles
        tick(); rst = 1'b1;
        @(negedge clk); chk("flush1_stallf", hz.StallF, 1); chk("flush1_flushd", hz.FlushD, 1);
        @(negedge clk); chk("flush2_stallf", hz.StallF, 1); chk("flush2_flushe", hz.FlushE, 1);
        @(negedge clk); chk("run_stallf", hz.StallF, 0); chk("run_flushw", hz.FlushW, 0);

        // Load-use hazard on rs2
        tick(); set_load_use(5'd5);
        @(negedge clk);
        chk("lu_stallf", hz.StallF, 1); chk("lu_stalld", hz.StallD, 1);
        chk("lu_flushe", hz.FlushE, 1); chk("lu_flushd", hz.FlushD, 0);
        tick(); idle();
        @(negedge clk); chk("lu_after_stallf", hz.StallF, 0); chk("lu_count", hz.StallCount, 1);
        tick(); set_load_use(5'd0);
        @(negedge clk); chk("lu_x0_stallf", hz.StallF, 0); chk("lu_x0_flushe", hz.FlushE, 0);

        // Forwarding priority
        tick(); idle();
        hz.RdM = 7; hz.RdW = 7; hz.Rs1E = 7; hz.RegWriteM = 1; hz.RegWriteW = 1;
        @(negedge clk); chk("fwd_a_m", hz.ForwardAE, 2'b10); chk("fwd_b_none", hz.ForwardBE, 2'b00);
        tick(); hz.RegWriteM = 0;
        @(negedge clk); chk("fwd_a_w", hz.ForwardAE, 2'b01);
        tick(); hz.Rs1E = 0;
        @(negedge clk); chk("fwd_a_x0", hz.ForwardAE, 2'b00);
        tick(); hz.Rs2E = 9; hz.RdW = 9; hz.RdM = 3; hz.RegWriteM = 1;
        @(negedge clk); chk("fwd_b_w", hz.ForwardBE, 2'b01);

        // Taken branch overrides load-use
        tick(); idle(); set_load_use(5'd5); hz.PCSrcE = 1;
        @(negedge clk);
        chk("br_flushd", hz.FlushD, 1); chk("br_flushe", hz.FlushE, 1); chk("br_stallf", hz.StallF, 0);

        // Memory wait of three cycles, with a branch ignored mid-stall
        tick(); idle(); hz.MemReqM = 1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin set_load_use(5'd5); hz.PCSrcE = 1; end
            @(negedge clk);
            chk("mw_stallf", hz.StallF, 1); chk("mw_stallm", hz.StallM, 1);
            chk("mw_flushw", hz.FlushW, 1); chk("mw_flushd", hz.FlushD, 0);
            tick();
        end
        idle(); hz.MemReqM = 1; hz.MemReadyM = 1;
        @(negedge clk); chk("mw_rel_stallf", hz.StallF, 0); chk("mw_rel_flushw", hz.FlushW, 0);
        tick(); idle();
        @(negedge clk); chk("mw_count", hz.StallCount, 4); chk("mw_err", hz.MemErr, 0);

        // Timeout: fifteen stall cycles, then forced release with a sticky error
        tick(); hz.MemReqM = 1;
        for (int i = 0; i < MT; i++) begin
            @(negedge clk); chk("to_stallm", hz.StallM, 1);
            tick();
        end
        @(negedge clk);
        chk("to_rel_stallf", hz.StallF, 0); chk("to_rel_flushw", hz.FlushW, 0);
        chk("to_rel_err", hz.MemErr, 0);
        tick(); idle();
        @(negedge clk); chk("to_err", hz.MemErr, 1); chk("to_count", hz.StallCount, 19);
        tick();
        @(negedge clk); chk("to_err_sticky", hz.MemErr, 1);

        // Saturation of the 5-bit counter: 19 + 14 stall cycles caps at 31
        tick(); set_load_use(5'd5);
        for (int i = 0; i < 14; i++) tick();
        idle();
        @(negedge clk); chk("count_sat", hz.StallCount, 31); chk("sat_err", hz.MemErr, 1);

        // Reset asserted in the middle of a memory wait
        tick(); hz.MemReqM = 1; hz.Rs1E = 7; hz.RdM = 7; hz.RegWriteM = 1;
        tick();
        @(negedge clk); chk("pre_rst_stallm", hz.StallM, 1);
        #2 rst = 1'b0;
        #1;
        chk("rst_stallf", hz.StallF, 1); chk("rst_stallm", hz.StallM, 0);
        chk("rst_flushd", hz.FlushD, 1); chk("rst_fwd", hz.ForwardAE, 2'b00);
        chk("rst_err", hz.MemErr, 0); chk("rst_count", hz.StallCount, 0);
        tick(); idle(); rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("rerun_stallf", hz.StallF, 0); chk("rerun_count", hz.StallCount, 0);

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
